// File: rtl/uart_output_queue.sv
// Output word FIFO feeding a UART 8N1 serialiser. Entries are {len, data}; 4-byte words go out
// little-endian as back-to-back frames, and output_stall back-pressures the core while the FIFO is full.
module uart_output_queue #(
  parameter int CLK_PER_HALF_BIT = 30,
  parameter int DEPTH_LOG2       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] send_data,
  input  logic [1:0]  core_sig,
  output logic        txd,
  output logic        output_stall,
  output logic        busy,
  output logic        overflow
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int BIT_CYC = 2 * CLK_PER_HALF_BIT;
  localparam int CW      = $clog2(BIT_CYC);
  localparam logic [CW-1:0]         CYC_LAST   = CW'(BIT_CYC - 1);
  localparam logic [DEPTH_LOG2:0]   COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [32:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  state_t                state;
  logic [CW-1:0]         cyc;
  logic [2:0]            bit_idx;
  logic [2:0]            bytes_left;
  logic [31:0]           shift;
  logic                  full;
  logic                  push;
  logic                  push_ok;
  logic                  pop;

  // A push while full is dropped even if the serialiser pops in the same cycle.
  assign full         = (count == COUNT_FULL);
  assign push         = core_sig[1];
  assign push_ok      = push & ~full;
  assign pop          = (state == IDLE) && (count != '0);
  assign output_stall = full;
  assign busy         = (count != '0) || (state != IDLE);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {core_sig[0], send_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)     rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
        default: ;
      endcase
      if (push & full) overflow <= 1'b1;
    end
  end

  // txd is registered, so the line lags the state by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      txd        <= 1'b1;
      cyc        <= '0;
      bit_idx    <= '0;
      bytes_left <= '0;
      shift      <= '0;
    end else begin
      case (state)
        IDLE: begin
          txd     <= 1'b1;
          cyc     <= '0;
          bit_idx <= '0;
          if (pop) begin
            shift      <= mem[rd_ptr][31:0];
            bytes_left <= mem[rd_ptr][32] ? 3'd4 : 3'd1;
            state      <= START;
          end
        end
        START: begin
          txd <= 1'b0;
          if (cyc == CYC_LAST) begin
            cyc   <= '0;
            state <= DATA;
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        DATA: begin
          txd <= shift[bit_idx];
          if (cyc == CYC_LAST) begin
            cyc <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        STOP: begin
          txd <= 1'b1;
          if (cyc == CYC_LAST) begin
            cyc <= '0;
            if (bytes_left > 3'd1) begin
              bytes_left <= bytes_left - 3'd1;
              shift      <= {8'h00, shift[31:8]};
              state      <= START;
            end else begin
              bytes_left <= '0;
              state      <= IDLE;
            end
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_output_queue.sv
// Directed bench for uart_output_queue: a UART receiver decodes txd into a byte scoreboard,
// and the main sequence checks reset, latency, framing spacing, full/overflow and mid-frame reset.
module tb_uart_output_queue;

  localparam int HALF = 4;
  localparam int BIT  = 2 * HALF;
  localparam int DL2  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] send_data = '0;
  logic [1:0]  core_sig = 2'b00;
  logic        txd;
  logic        output_stall;
  logic        busy;
  logic        overflow;

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;

  logic [7:0]  exp_q[$];
  int          st_q[$];
  logic [31:0] w4 [6];

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  uart_output_queue #(.CLK_PER_HALF_BIT(HALF), .DEPTH_LOG2(DL2)) dut (
    .clk          (clk),
    .rst          (rst),
    .send_data    (send_data),
    .core_sig     (core_sig),
    .txd          (txd),
    .output_stall (output_stall),
    .busy         (busy),
    .overflow     (overflow)
  );

  task automatic check1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    checks++;
    assert (obs == expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // driver tasks
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [1:0] sig, input logic [31:0] d);
    core_sig  = sig;
    send_data = d;
    @(posedge clk);
    #1;
    core_sig  = 2'b00;
    send_data = $urandom;
  endtask

  task automatic expect_word(input logic len, input logic [31:0] d);
    exp_q.push_back(d[7:0]);
    if (len) begin
      exp_q.push_back(d[15:8]);
      exp_q.push_back(d[23:16]);
      exp_q.push_back(d[31:24]);
    end
  endtask

  task automatic wait_drain(input string tag, input int bound);
    int n;
    n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < bound) begin
      tick();
      n++;
    end
    check1({tag, "_busy_low"}, busy, 1'b0);
    check_int({tag, "_all_bytes_seen"}, exp_q.size(), 0);
  endtask

  // receiver + scoreboard: samples each bit at its centre, drops frames cut by reset
  logic [7:0] rx_b;
  logic [7:0] rx_e;
  logic       rx_abort;
  logic       rx_frame_ok;
  int         rx_start;

  always begin
    @(negedge clk);
    if (!rst && txd === 1'b0) begin
      rx_start    = cyc_n;
      rx_abort    = 1'b0;
      rx_frame_ok = 1'b1;
      rx_b        = '0;
      for (int i = 0; i < 10; i++) begin
        for (int c = 0; c < ((i == 0) ? HALF : BIT); c++) begin
          @(negedge clk);
          if (rst) begin
            rx_abort = 1'b1;
            break;
          end
        end
        if (rx_abort) break;
        if (i == 0)      rx_frame_ok = rx_frame_ok & (txd === 1'b0);
        else if (i == 9) rx_frame_ok = rx_frame_ok & (txd === 1'b1);
        else             rx_b[i-1] = txd;
      end
      if (!rx_abort) begin
        st_q.push_back(rx_start);
        check1("rx_framing", rx_frame_ok, 1'b1);
        rx_e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check8("rx_byte", rx_b, rx_e);
      end
    end
  end

  initial begin
    w4[0] = 32'h01020304;
    w4[1] = 32'h11223344;
    w4[2] = 32'h55667788;
    w4[3] = 32'h99AABBCC;
    w4[4] = 32'hDDEEFF00;
    w4[5] = 32'hBAD0BAD0;

    // reset for two cycles, then quiet idle
    tick(2);
    rst = 1'b0;
    check1("t1_txd", txd, 1'b1);
    check1("t1_stall", output_stall, 1'b0);
    check1("t1_busy", busy, 1'b0);
    check1("t1_overflow", overflow, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check1("t1_idle_txd", txd, 1'b1);
      check1("t1_idle_busy", busy, 1'b0);
    end

    // single byte: txd falls two edges after the push edge
    expect_word(1'b0, 32'h12345641);
    push(2'b10, 32'h12345641);
    check1("t2_busy_after_push", busy, 1'b1);
    check1("t2_txd_push_edge", txd, 1'b1);
    tick();
    check1("t2_txd_pop_edge", txd, 1'b1);
    tick();
    check1("t2_txd_start", txd, 1'b0);
    wait_drain("t2", 200);
    check1("t2_txd_idle", txd, 1'b1);
    tick(5);

    // 4-byte word: back-to-back frames, little-endian
    st_q.delete();
    expect_word(1'b1, 32'hDEADBEEF);
    push(2'b11, 32'hDEADBEEF);
    wait_drain("t3", 500);
    check_int("t3_frames", st_q.size(), 4);
    for (int i = 1; i < st_q.size(); i++)
      check_int("t3_frame_spacing", st_q[i] - st_q[i-1], 80);
    tick(5);

    // fill the FIFO, then one push while full
    st_q.delete();
    for (int i = 0; i < 5; i++) expect_word(1'b1, w4[i]);
    for (int i = 0; i < 4; i++) push(2'b11, w4[i]);
    check1("t4_stall_before_full", output_stall, 1'b0);
    push(2'b11, w4[4]);
    check1("t4_stall_full", output_stall, 1'b1);
    check1("t4_overflow_before", overflow, 1'b0);
    check1("t4_busy_full", busy, 1'b1);
    push(2'b11, w4[5]);
    check1("t4_overflow_set", overflow, 1'b1);
    check1("t4_stall_still", output_stall, 1'b1);
    wait_drain("t4", 3000);
    check_int("t4_frames", st_q.size(), 20);
    for (int i = 1; i < st_q.size(); i++)
      check_int("t4_frame_spacing", st_q[i] - st_q[i-1], ((i % 4) == 0) ? 81 : 80);
    check1("t4_overflow_sticky", overflow, 1'b1);
    check1("t4_stall_drained", output_stall, 1'b0);
    tick(5);

    // eight spaced single bytes: pointers wrap
    for (int i = 0; i < 8; i++) begin
      check1("t5_stall", output_stall, 1'b0);
      expect_word(1'b0, {24'h0, i[7:0]});
      push(2'b10, {24'hA5A5A5, i[7:0]});
      tick(60);
    end
    wait_drain("t5", 1000);
    tick(5);

    // reset in the middle of a data bit, with a word still queued
    push(2'b11, 32'hCAFEF00D);
    push(2'b10, 32'h00000077);
    tick(30);
    check1("t6_busy_mid", busy, 1'b1);
    rst = 1'b1;
    tick();
    check1("t6_txd_reset", txd, 1'b1);
    check1("t6_busy_reset", busy, 1'b0);
    check1("t6_stall_reset", output_stall, 1'b0);
    check1("t6_overflow_reset", overflow, 1'b0);
    rst = 1'b0;
    tick(100);
    check1("t6_txd_quiet", txd, 1'b1);
    check1("t6_busy_quiet", busy, 1'b0);
    expect_word(1'b0, 32'h0000005A);
    push(2'b10, 32'h0000005A);
    wait_drain("t6", 200);

    // final report
    tick(20);
    check_int("end_scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
